sccb_master_mb: RTL and testbench
=================================

# sccb_master_mb

Parametrised SCCB master for camera-sensor configuration. It runs write and two-phase read transactions with 1- or 2-byte register sub-addresses and up to MAX_BYTES data bytes per transaction. It checks slave acknowledge bits and can optionally abort on a missing acknowledge. It sits between the register/config logic (single-pulse command interface) and the sensor's SIO_C/SIO_D pins (tristate driven externally from the data output/enable pair).

## Interface
- ADDR_BYTES, 2: sub-address width in bytes; legal values 1 or 2.
- MAX_BYTES, 4: maximum data bytes per transaction; legal range 1..4.
- ACK_CHECK, 1: 1 aborts on a sampled slave NACK; 0 only flags it.
- NB_W = $clog2(MAX_BYTES+1) (local): width of `nbytes`.
---
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- clk_div  in  16  quarter-bit length minus 1, in clk cycles; sampled on an accepted start.
- start  in  1  one-cycle command strobe.
- rw  in  1  0 = write, 1 = read.
- dev_id  in  7  7-bit device ID.
- sub_addr  in  8*ADDR_BYTES  register address, sent MSB byte first.
- wr_data  in  8*MAX_BYTES  write bytes; byte 0 is the LSB byte, sent first.
- nbytes  in  NB_W  data byte count.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- ack_err  out  1  a NACK was seen in the last transaction; valid from `done`.
- rd_data  out  8*MAX_BYTES  received bytes.
- sccb_clk  out  1  SIO_C.
- sccb_data_out  out  1  SIO_D drive value.
- sccb_data_en  out  1  1 = master drives SIO_D.
- sccb_data_in  in  1  SIO_D sampled value.

## Operation
**Command acceptance**
- `start` is accepted only in IDLE.
- On acceptance, latch all command inputs and `clk_div`, clear `ack_err` and `rd_data`.
- `start` while busy is ignored.

**FSM states:** IDLE, START, BYTE, ACK, STOP, GAP.

**Write (rw = 0)**
- Sequence: START, {dev_id, 0}, ACK, sub_addr bytes each followed by ACK, `nbytes` wr_data bytes each followed by ACK, STOP.
- `nbytes = 0` is an address-only write.

**Read (rw = 1)**
- Phase 1: START, {dev_id, 0}, ACK, sub_addr bytes each followed by ACK, STOP.
- GAP of one bit time.
- Phase 2: START, {dev_id, 1}, ACK, then N received bytes, where N = max(nbytes, 1), clamped to MAX_BYTES.
- After each received byte the master drives an ACK bit: 0 between bytes, 1 (NA) after the last byte. Then STOP.

**Slave ACK bits**
- `sccb_data_en = 0`; sample `sccb_data_in`; sampled 1 sets `ack_err`.
- If ACK_CHECK = 1 and a NACK is sampled, go directly to STOP after that bit. `done` still pulses.

**Received data**
- Shift left by byte: `rd_data <= {rd_data, byte}`, with the byte MSB-first on the wire.
- Example: bytes 0x56 then 0x40 give `rd_data[15:0] = 0x5640`.

**Data enable**
- `sccb_data_en = 0` during slave ACK bits and received data bits.
- `sccb_data_en = 1` at all other times, including IDLE.

**Length clamping:** `nbytes > MAX_BYTES` is clamped to MAX_BYTES.

## Timing
**Base units**
- Quarter Q = clk_div + 1 clk cycles; every bit, START and STOP lasts 4Q.
- `clk_div = 0` gives Q = 1 clk.

**Per-quarter pin levels (q0..q3)**
- START: SDA 1,0,0,0; SCL 1,1,1,0.
- Data/ACK bit:
  - SDA changes at q0 entry.
  - SCL is 0,1,1,0.
  - Input is sampled on the first clk of q2.
- STOP: SDA 0,0,1,1; SCL 0,1,1,1.
- GAP and IDLE: SDA = 1, SCL = 1.

**Handshake latency**
- `busy` rises on the clk edge after the accepted `start`, and the START q0 begins on that edge.
- `done` pulses and `busy` falls on the same edge, when STOP q3 ends.
- The next `start` is accepted in the cycle `done` is high or any later cycle.

**Totals**
- Write, ADDR_BYTES = 2, nbytes = 1: 4Q + 4·36Q + 4Q = 152Q.
- Read, ADDR_BYTES = 1, nbytes = 1: 4Q + 72Q + 4Q + 4Q + 4Q + 72Q + 4Q = 164Q.

**Reset values:** busy = 0, done = 0, ack_err = 0, rd_data = 0, sccb_clk = 1, sccb_data_out = 1, sccb_data_en = 1.

**Reset and collision rules**
- `rst` mid-transaction returns to IDLE on the next edge with the reset values; no STOP is generated.
- `rst` and `start` in the same cycle: `rst` wins.
- The quarter counter wraps at `clk_div`.
- A `clk_div` change mid-transaction has no effect.

## Test plan
- **16-bit address write.** ADDR_BYTES = 2, clk_div = 3, write dev_id 0x3C, sub_addr 0x3008, nbytes 1, wr_data 0x82, slave ACKs all bits.
  - SDA bits: 0x78, 0x30, 0x08, 0x82.
  - `done` after 152·4 clk; ack_err = 0.
- **Two-byte read.** Read dev 0x3C, sub_addr 0x300A, nbytes 2, slave returns 0x56, 0x40.
  - STOP + GAP + repeated START appear; second ID byte is 0x79.
  - Master ACK bits are 0 then 1; `rd_data[15:0] = 0x5640`.
- **NACK abort.** ACK_CHECK = 1, slave NACKs the first sub-address byte.
  - STOP follows immediately; ack_err = 1; `done` pulses; wr_data is never sent.
- **NACK flag only.** ACK_CHECK = 0 with the same NACK: the full transaction completes and ack_err = 1.
- **Start while busy.** Pulse `start` with different data while busy: ignored, and the original transaction's bits are unchanged.
- **Reset mid-transaction.** Assert `rst` during a data byte: next edge busy = 0, sccb_clk = 1, sccb_data_out = 1, sccb_data_en = 1. A following write with clk_div = 0 completes correctly.

Source files
------------

// File: rtl/sccb_master_mb_if.sv
// sccb_master_mb_if: command/status bundle between the register/config logic
// and the SCCB master.
interface sccb_master_mb_if #(
    parameter int ADDR_BYTES = 2,
    parameter int MAX_BYTES  = 4
);
    localparam int NB_W = $clog2(MAX_BYTES + 1);
    logic [15:0]             clk_div;
    logic                    start;
    logic                    rw;
    logic [6:0]              dev_id;
    logic [8*ADDR_BYTES-1:0] sub_addr;
    logic [8*MAX_BYTES-1:0]  wr_data;
    logic [NB_W-1:0]         nbytes;
    logic                    busy;
    logic                    done;
    logic                    ack_err;
    logic [8*MAX_BYTES-1:0]  rd_data;
    modport master (
        output clk_div, start, rw, dev_id, sub_addr, wr_data, nbytes,
        input  busy, done, ack_err, rd_data
    );
    modport slave (
        input  clk_div, start, rw, dev_id, sub_addr, wr_data, nbytes,
        output busy, done, ack_err, rd_data
    );
endinterface

// File: rtl/sccb_master_mb.sv
// sccb_master_mb: SCCB master for sensor configuration; write and two-phase read
// transactions with 1/2-byte sub-addresses, up to MAX_BYTES data bytes, ACK checking.
module sccb_master_mb #(
    parameter int ADDR_BYTES = 2,
    parameter int MAX_BYTES  = 4,
    parameter bit ACK_CHECK  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    sccb_master_mb_if.slave cmd,
    output logic            sccb_clk,
    output logic            sccb_data_out,
    output logic            sccb_data_en,
    input  logic            sccb_data_in
);
    localparam int NB_W = $clog2(MAX_BYTES + 1);
    localparam int AW   = 8 * ADDR_BYTES;
    localparam int DW   = 8 * MAX_BYTES;

    typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP, GAP} state_t;
    state_t state, nxt;

    logic [15:0]     div_q, qcnt;
    logic [1:0]      q;
    logic [2:0]      bit_idx, bcnt, last;
    logic            ph, rd_q, ack_err, done;
    logic [6:0]      dev_q;
    logic [AW-1:0]   sub_q;
    logic [DW-1:0]   wr_q, rd_data;
    logic [NB_W-1:0] nb_q, nb_in;
    logic [7:0]      tx_byte;
    logic            tick, qend, sample, rxing, abort;

    assign nb_in  = (cmd.nbytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : cmd.nbytes;
    assign tick   = qcnt == div_q;
    assign qend   = tick && q == 2'd3;
    assign sample = qcnt == 16'd0 && q == 2'd2;
    assign rxing  = rd_q && ph && bcnt != 3'd0;
    assign abort  = ACK_CHECK && ack_err;
    // bcnt indexes the bytes of the current phase: 0 is the ID byte
    assign last = rd_q ? (ph ? (nb_q == '0 ? 3'd1 : 3'(nb_q)) : 3'(ADDR_BYTES))
                       : 3'(ADDR_BYTES) + 3'(nb_q);
    assign tx_byte = bcnt == 3'd0 ? {dev_q, rd_q & ph}
                   : int'(bcnt) <= ADDR_BYTES ? 8'(sub_q >> (8 * (ADDR_BYTES - int'(bcnt))))
                   : 8'(wr_q >> (8 * (int'(bcnt) - 1 - ADDR_BYTES)));

    assign cmd.busy    = state != IDLE;
    assign cmd.done    = done;
    assign cmd.ack_err = ack_err;
    assign cmd.rd_data = rd_data;

    always_comb begin
        nxt           = state;
        sccb_clk      = 1'b1;
        sccb_data_out = 1'b1;
        sccb_data_en  = 1'b1;
        case (state)
            IDLE: nxt = cmd.start ? START : IDLE;
            START: begin
                sccb_data_out = q == 2'd0;
                sccb_clk      = q != 2'd3;
                if (qend) nxt = BYTE;
            end
            BYTE: begin
                sccb_clk      = q == 2'd1 || q == 2'd2;
                sccb_data_out = rxing | tx_byte[3'd7 - bit_idx];
                sccb_data_en  = !rxing;
                if (qend && bit_idx == 3'd7) nxt = ACK;
            end
            ACK: begin
                sccb_clk      = q == 2'd1 || q == 2'd2;
                sccb_data_out = !rxing || bcnt == last;
                sccb_data_en  = rxing;
                if (qend) nxt = (abort || bcnt == last) ? STOP : BYTE;
            end
            STOP: begin
                sccb_data_out = q[1];
                sccb_clk      = q != 2'd0;
                if (qend) nxt = (rd_q && !ph && !abort) ? GAP : IDLE;
            end
            GAP: if (qend) nxt = START;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (rst) begin
            state   <= IDLE;
            qcnt    <= '0;
            q       <= '0;
            bit_idx <= '0;
            bcnt    <= '0;
            ph      <= 1'b0;
            ack_err <= 1'b0;
            rd_data <= '0;
            div_q   <= '0;
            rd_q    <= 1'b0;
            dev_q   <= '0;
            sub_q   <= '0;
            wr_q    <= '0;
            nb_q    <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE) begin
                if (cmd.start) begin
                    div_q   <= cmd.clk_div;
                    rd_q    <= cmd.rw;
                    dev_q   <= cmd.dev_id;
                    sub_q   <= cmd.sub_addr;
                    wr_q    <= cmd.wr_data;
                    nb_q    <= nb_in;
                    ack_err <= 1'b0;
                    rd_data <= '0;
                    qcnt    <= '0;
                    q       <= '0;
                    bcnt    <= '0;
                    bit_idx <= '0;
                    ph      <= 1'b0;
                end
            end else begin
                qcnt <= tick ? 16'd0 : qcnt + 16'd1;
                if (tick) q <= q + 2'd1;
                if (sample && state == ACK && !rxing) ack_err <= ack_err | sccb_data_in;
                if (sample && state == BYTE && rxing) rd_data <= {rd_data[DW-2:0], sccb_data_in};
                if (qend && state == BYTE) bit_idx <= bit_idx + 3'd1;
                if (qend && state == ACK && nxt == BYTE) bcnt <= bcnt + 3'd1;
                if (qend && state == GAP) begin
                    ph   <= 1'b1;
                    bcnt <= '0;
                end
                if (qend && state == STOP && nxt == IDLE) done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sccb_master_mb.sv
// tb_sccb_master_mb: a bus monitor decodes SIO_C/SIO_D into START/STOP/frame tokens and a
// done monitor checks status; both pop expectations queued by the stimulus.
module tb_sccb_master_mb;
    localparam int ST = 'h400;
    localparam int SP = 'h401;
    typedef struct {logic ack; logic [31:0] rd; int cyc;} exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        start = 1'b0, rw = 1'b0, sel = 1'b0;
    logic [6:0]  dev_id = '0;
    logic [15:0] sub_addr = '0, clk_div = '0;
    logic [31:0] wr_data = '0;
    logic [2:0]  nbytes = '0;
    logic        scl0, out0, en0, scl1, out1, en1;
    logic        sccb_clk, dout, den, sda;
    logic        slv_drv = 1'b1;
    logic        busy, done, ack_err;
    logic [31:0] rd_data;
    int          checks = 0, failures = 0, cyc = 0, ndone = 0, n_issue = 0;
    int          nack_frame = -1, frame = 0, bitpos = 0;
    logic        rd_mode = 1'b0, pscl = 1'b1, psda = 1'b1, mon_en = 1'b0;
    logic [8:0]  shreg = '0;
    logic [7:0]  rx_bytes [4];
    int          exp_tok [$];
    exp_t        exp_q [$];

    sccb_master_mb_if #(.ADDR_BYTES(2), .MAX_BYTES(4)) c0 ();
    sccb_master_mb_if #(.ADDR_BYTES(2), .MAX_BYTES(4)) c1 ();

    sccb_master_mb #(.ADDR_BYTES(2), .MAX_BYTES(4), .ACK_CHECK(1'b1)) u0 (
        .clk(clk), .rst(rst), .cmd(c0), .sccb_clk(scl0), .sccb_data_out(out0),
        .sccb_data_en(en0), .sccb_data_in(sda));
    sccb_master_mb #(.ADDR_BYTES(2), .MAX_BYTES(4), .ACK_CHECK(1'b0)) u1 (
        .clk(clk), .rst(rst), .cmd(c1), .sccb_clk(scl1), .sccb_data_out(out1),
        .sccb_data_en(en1), .sccb_data_in(sda));

    assign c0.start    = start & ~sel;
    assign c1.start    = start & sel;
    assign c0.rw       = rw;
    assign c1.rw       = rw;
    assign c0.dev_id   = dev_id;
    assign c1.dev_id   = dev_id;
    assign c0.sub_addr = sub_addr;
    assign c1.sub_addr = sub_addr;
    assign c0.wr_data  = wr_data;
    assign c1.wr_data  = wr_data;
    assign c0.nbytes   = nbytes;
    assign c1.nbytes   = nbytes;
    assign c0.clk_div  = clk_div;
    assign c1.clk_div  = clk_div;

    assign sccb_clk = sel ? scl1 : scl0;
    assign dout     = sel ? out1 : out0;
    assign den      = sel ? en1 : en0;
    assign sda      = den ? dout : slv_drv;
    assign busy     = sel ? c1.busy : c0.busy;
    assign done     = sel ? c1.done : c0.done;
    assign ack_err  = sel ? c1.ack_err : c0.ack_err;
    assign rd_data  = sel ? c1.rd_data : c0.rd_data;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, a, e);
        end
    endtask

    task automatic tok(input int v);
        if (mon_en) begin
            if (exp_tok.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL bus_token got=%0h exp=none", v);
            end else chk("bus_token", v, exp_tok.pop_front());
        end
    endtask

    function automatic logic drv(input int f, input int b);
        if (rd_mode && f > 0 && f <= 4) return b < 8 ? rx_bytes[f-1][7-b] : 1'b1;
        if (b == 8) return f == nack_frame && !rd_mode;
        return 1'b1;
    endfunction

    // slave model: decodes the resolved line and drives ACKs / read data while SCL is low
    always @(sccb_clk or sda) begin
        if (sccb_clk && pscl && psda && !sda) begin
            tok(ST);
            frame   = 0;
            bitpos  = 0;
            rd_mode = 1'b0;
        end else if (sccb_clk && pscl && !psda && sda) tok(SP);
        else if (sccb_clk && !pscl) begin
            shreg  = {shreg[7:0], sda};
            bitpos = bitpos + 1;
            if (frame == 0 && bitpos == 8) rd_mode = shreg[0];
            if (bitpos == 9) begin
                tok(int'(shreg));
                frame  = frame + 1;
                bitpos = 0;
            end
        end else if (!sccb_clk && pscl) slv_drv = drv(frame, bitpos);
        pscl = sccb_clk;
        psda = sda;
    end

    always @(negedge clk) begin : dmon
        exp_t e;
        if (done) begin
            ndone++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected ack_err=%0b rd_data=%0h", ack_err, rd_data);
            end else begin
                e = exp_q.pop_front();
                chk("ack_err", 32'(ack_err), 32'(e.ack));
                chk("rd_data", rd_data, e.rd);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic st();
        exp_tok.push_back(ST);
    endtask
    task automatic sp();
        exp_tok.push_back(SP);
    endtask
    task automatic fr(input logic [7:0] b, input logic a = 1'b0);
        exp_tok.push_back(int'({b, a}));
    endtask

    task automatic issue(input logic s, input logic r, input logic [6:0] id,
                         input logic [15:0] sa, input logic [31:0] wd, input logic [2:0] nb,
                         input logic [15:0] div, input logic ea, input logic [31:0] er,
                         input int t);
        exp_t e;
        @(negedge clk);
        n_issue  = ndone;
        sel      = s;
        rw       = r;
        dev_id   = id;
        sub_addr = sa;
        wr_data  = wd;
        nbytes   = nb;
        clk_div  = div;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_rise", 32'(busy), 32'd1);
        e.ack = ea;
        e.rd  = er;
        e.cyc = cyc + t;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int t);
        for (int i = 0; i < t + 64 && ndone == n_issue; i++) @(negedge clk);
        chk("done_seen", 32'(ndone != n_issue), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic run(input logic s, input logic r, input logic [6:0] id,
                       input logic [15:0] sa, input logic [31:0] wd, input logic [2:0] nb,
                       input logic [15:0] div, input logic ea, input logic [31:0] er,
                       input int t);
        issue(s, r, id, sa, wd, nb, div, ea, er, t);
        wait_done(t);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_bytes = '{8'h56, 8'h40, 8'h00, 8'h00};
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ack_err", 32'(ack_err), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_scl", 32'(sccb_clk), 32'd1);
        chk("rst_sda_out", 32'(dout), 32'd1);
        chk("rst_sda_en", 32'(den), 32'd1);
        rst    = 1'b0;
        mon_en = 1'b1;

        // 16-bit address write, Q = 4
        st(); fr(8'h78); fr(8'h30); fr(8'h08); fr(8'h82); sp();
        run(1'b0, 1'b0, 7'h3C, 16'h3008, 32'h82, 3'd1, 16'd3, 1'b0, 32'h0, 608);

        // two-byte read, Q = 2
        st(); fr(8'h78); fr(8'h30); fr(8'h0A); sp();
        st(); fr(8'h79); fr(8'h56, 1'b0); fr(8'h40, 1'b1); sp();
        run(1'b0, 1'b1, 7'h3C, 16'h300A, 32'h0, 3'd2, 16'd1, 1'b0, 32'h5640, 472);

        // NACK on first sub-address byte: abort vs flag only
        nack_frame = 1;
        st(); fr(8'h42); fr(8'h12, 1'b1); sp();
        run(1'b0, 1'b0, 7'h21, 16'h1234, 32'hBEEF, 3'd2, 16'd0, 1'b1, 32'h0, 80);
        st(); fr(8'h42); fr(8'h12, 1'b1); fr(8'h34); fr(8'hEF); fr(8'hBE); sp();
        run(1'b1, 1'b0, 7'h21, 16'h1234, 32'hBEEF, 3'd2, 16'd0, 1'b1, 32'h0, 188);
        nack_frame = -1;

        // start (and clk_div change) while busy is ignored
        st(); fr(8'h78); fr(8'h01); fr(8'h02); fr(8'hAA); fr(8'hBB); fr(8'hCC); sp();
        issue(1'b0, 1'b0, 7'h3C, 16'h0102, 32'h00CCBBAA, 3'd3, 16'd2, 1'b0, 32'h0, 672);
        repeat (50) @(negedge clk);
        rw = 1'b1; dev_id = 7'h11; sub_addr = 16'hFFFF; wr_data = '0; nbytes = 3'd1;
        clk_div = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_hold", 32'(busy), 32'd1);
        wait_done(672);

        // read with nbytes = 0 receives one byte
        rx_bytes[0] = 8'hA5;
        st(); fr(8'h84); fr(8'h00); fr(8'hFF); sp();
        st(); fr(8'h85); fr(8'hA5, 1'b1); sp();
        run(1'b0, 1'b1, 7'h42, 16'h00FF, 32'h0, 3'd0, 16'd0, 1'b0, 32'hA5, 200);

        // nbytes = 6 clamps to 4 data bytes
        st(); fr(8'h78); fr(8'h11); fr(8'h22); fr(8'h11); fr(8'h22); fr(8'h33); fr(8'h44); sp();
        run(1'b1, 1'b0, 7'h3C, 16'h1122, 32'h44332211, 3'd6, 16'd0, 1'b0, 32'h0, 260);

        // address-only write
        st(); fr(8'h78); fr(8'hAB); fr(8'hCD); sp();
        run(1'b0, 1'b0, 7'h3C, 16'hABCD, 32'h0, 3'd0, 16'd0, 1'b0, 32'h0, 116);

        // reset during a data byte, then a clean write with clk_div = 0
        mon_en = 1'b0;
        @(negedge clk);
        sel = 1'b0; rw = 1'b0; dev_id = 7'h3C; sub_addr = 16'h3008; wr_data = 32'h82;
        nbytes = 3'd1; clk_div = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (380) @(negedge clk);
        chk("busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_scl", 32'(sccb_clk), 32'd1);
        chk("midrst_sda_out", 32'(dout), 32'd1);
        chk("midrst_sda_en", 32'(den), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        exp_tok.delete();
        mon_en = 1'b1;
        st(); fr(8'h78); fr(8'h30); fr(8'h08); fr(8'h82); sp();
        run(1'b0, 1'b0, 7'h3C, 16'h3008, 32'h82, 3'd1, 16'd0, 1'b0, 32'h0, 152);

        chk("tokens_left", exp_tok.size(), 32'd0);
        chk("done_left", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
